// File: rtl/fbmult_multi.sv
// fbmult_multi: multi-bunch feedback multiplier. Each sample's charge*signal
// product is added to a delayed term kept separately for every bunch in the
// store window. The sum is sliced to a signed feedback output.
//
// Optional feature: define FBMULT_SAT_EN to clip DSPout at the signed OUT_W
// range and raise sat_flag. Without it, DSPout is the plain wrapping slice
// and sat_flag stays 0.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   charge_in   signed charge operand (CHARGE_W)
//   signal_in   signed position signal operand (SIG_W)
//   delay_en    enables the delayed-term update
//   store_strb  store window; low clears the datapath on the next edge
//   bunch_strb  bunch start marker
//   DSPout      registered signed feedback output (OUT_W)
//   bunch_idx   bunch index aligned with DSPout
//   out_valid   DSPout carries a store-window result
//   sat_flag    DSPout clipped this cycle
module fbmult_multi #(
  parameter int unsigned NUM_SMPLS_INTEG = 4,
  parameter int unsigned NUM_BUNCH       = 3,
  parameter int unsigned CHARGE_W        = 21,
  parameter int unsigned SIG_W           = 15,
  parameter int unsigned OUT_W           = 13,
  parameter int unsigned OUT_SHIFT       = 12,
  localparam int unsigned IDX_W          = (NUM_BUNCH > 1) ? $clog2(NUM_BUNCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHARGE_W-1:0] charge_in,
  input  logic [SIG_W-1:0]    signal_in,
  input  logic                delay_en,
  input  logic                store_strb,
  input  logic                bunch_strb,
  output logic [OUT_W-1:0]    DSPout,
  output logic [IDX_W-1:0]    bunch_idx,
  output logic                out_valid,
  output logic                sat_flag
);

  localparam int unsigned DLY_W  = OUT_W + 3;
  localparam int unsigned PROD_W = CHARGE_W + SIG_W;
  localparam int unsigned ACC_W  = PROD_W + 1;
  localparam int unsigned LSH    = OUT_SHIFT - 3;
  localparam int unsigned HI_W   = ACC_W - (OUT_SHIFT + OUT_W) + 1;
  localparam logic [7:0]       SMP_LAST  = 8'(NUM_SMPLS_INTEG - 1);
  localparam logic [IDX_W-1:0] BUNCH_LAST = IDX_W'(NUM_BUNCH - 1);

  logic [7:0]              sample_ctr;
  logic [IDX_W-1:0]        bunch_ctr;
  logic                    upd;
  logic signed [PROD_W-1:0] prod;
  logic [IDX_W-1:0]        tag1;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        tag2;
  logic signed [DLY_W-1:0] delayed [NUM_BUNCH];
  logic [2:0]              valid_sr;

  logic                    clr_c;
  logic [IDX_W-1:0]        bunch_nxt_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0] acc_c;
  logic [OUT_W-1:0]        dsp_c;
  logic                    sat_c;
  logic                    unused_acc_c;

  // Reset and an idle store window both return the datapath to its start state
  assign clr_c = rst | ~store_strb;

  assign bunch_nxt_c = (bunch_ctr == BUNCH_LAST) ? '0 : bunch_ctr + IDX_W'(1);

  // Signed product and accumulation with the bunch's delayed term
  assign prod_c = PROD_W'($signed(charge_in)) * PROD_W'($signed(signal_in));
  assign acc_c  = ACC_W'(prod) + (ACC_W'(delayed[tag1]) <<< LSH);

  // Output slice, optionally clipped when the bits above it disagree with the sign
  always_comb begin
    dsp_c = acc[OUT_SHIFT+OUT_W-1:OUT_SHIFT];
    sat_c = 1'b0;
`ifdef FBMULT_SAT_EN
    if (acc[ACC_W-1:OUT_SHIFT+OUT_W-1] != {HI_W{acc[ACC_W-1]}}) begin
      sat_c = 1'b1;
      dsp_c = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  // Only a slice of acc reaches the outputs; fold the rest so it reads as used
  assign unused_acc_c = ^acc;

  // Sample/bunch counters and the registered update request
  always_ff @(posedge clk) begin
    if (clr_c) begin
      sample_ctr <= '0;
      bunch_ctr  <= BUNCH_LAST;
      upd        <= 1'b0;
    end else begin
      if (bunch_strb) begin
        sample_ctr <= '0;
        bunch_ctr  <= bunch_nxt_c;
      end else if (sample_ctr != 8'hFF) begin
        sample_ctr <= sample_ctr + 8'd1;
      end
      upd <= delay_en & (sample_ctr == SMP_LAST);
    end
  end

  // Three-stage datapath; the bunch tag travels with the data
  always_ff @(posedge clk) begin
    if (clr_c) begin
      prod      <= '0;
      tag1      <= '0;
      acc       <= '0;
      tag2      <= '0;
      DSPout    <= '0;
      bunch_idx <= '0;
      sat_flag  <= 1'b0;
    end else begin
      prod      <= prod_c;
      tag1      <= bunch_ctr;
      acc       <= acc_c;
      tag2      <= tag1;
      DSPout    <= dsp_c;
      bunch_idx <= tag2;
      sat_flag  <= sat_c;
    end
  end

  // Per-bunch delayed terms; the update targets the tag of the data in stage 2
  always_ff @(posedge clk) begin
    if (clr_c) begin
      for (int unsigned i = 0; i < NUM_BUNCH; i++) begin
        delayed[i] <= '0;
      end
    end else if (upd) begin
      delayed[tag2] <= acc[OUT_SHIFT+OUT_W-1:OUT_SHIFT-3];
    end
  end

  // out_valid is store_strb delayed to line up with DSPout
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[1:0], store_strb};
    end
  end

  assign out_valid = valid_sr[2];

endmodule

// File: tb/tb_fbmult_multi.sv
module tb_fbmult_multi;

  localparam int NSI = 4;
  localparam int NB  = 3;
  localparam int CW  = 21;
  localparam int SW  = 15;
  localparam int OW  = 13;
  localparam int OS  = 12;
  localparam int DW  = OW + 3;
  localparam int AW  = CW + SW + 1;
  localparam int IW  = 2;

  logic          clk;
  logic          rst;
  logic [CW-1:0] charge_in;
  logic [SW-1:0] signal_in;
  logic          delay_en;
  logic          store_strb;
  logic          bunch_strb;
  logic [OW-1:0] DSPout;
  logic [IW-1:0] bunch_idx;
  logic          out_valid;
  logic          sat_flag;

  int checks;
  int failures;

  // Behavioural reference state (plain integers)
  int     m_smp, m_bnk, m_upd;
  longint m_prod, m_acc, m_dsp;
  int     m_tag1, m_tag2, m_idx, m_sat;
  longint m_dly [NB];
  int     m_vq [3];

  fbmult_multi dut (
    .clk        (clk),
    .rst        (rst),
    .charge_in  (charge_in),
    .signal_in  (signal_in),
    .delay_en   (delay_en),
    .store_strb (store_strb),
    .bunch_strb (bunch_strb),
    .DSPout     (DSPout),
    .bunch_idx  (bunch_idx),
    .out_valid  (out_valid),
    .sat_flag   (sat_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keep the low w bits of v as a signed number
  function automatic longint sx(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_smp = 0; m_bnk = NB - 1; m_upd = 0;
    m_prod = 0; m_acc = 0; m_dsp = 0;
    m_tag1 = 0; m_tag2 = 0; m_idx = 0; m_sat = 0;
    for (int i = 0; i < NB; i++) m_dly[i] = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs now applied
  task automatic model_step();
    longint c, s, nprod, nacc, ndsp, sh, ld;
    int nsat;
    if (rst) begin
      model_clear();
      for (int i = 0; i < 3; i++) m_vq[i] = 0;
    end else begin
      m_vq[2] = m_vq[1]; m_vq[1] = m_vq[0]; m_vq[0] = int'(store_strb);
      if (!store_strb) begin
        model_clear();
      end else begin
        c     = sx(longint'(charge_in), CW);
        s     = sx(longint'(signal_in), SW);
        nprod = c * s;
        nacc  = sx(m_prod + m_dly[m_tag1] * (longint'(1) <<< (OS - 3)), AW);
        sh    = m_acc >>> OS;
        ndsp  = sx(sh, OW);
        nsat  = 0;
`ifdef FBMULT_SAT_EN
        if (sh > 4095) begin ndsp = 4095; nsat = 1; end
        else if (sh < -4096) begin ndsp = -4096; nsat = 1; end
`endif
        ld = sx(m_acc >>> (OS - 3), DW);
        if (m_upd != 0) m_dly[m_tag2] = ld;
        m_upd  = (delay_en && m_smp == NSI - 1) ? 1 : 0;
        m_dsp  = ndsp;
        m_sat  = nsat;
        m_idx  = m_tag2;
        m_tag2 = m_tag1;
        m_acc  = nacc;
        m_tag1 = m_bnk;
        m_prod = nprod;
        if (bunch_strb) begin
          m_smp = 0;
          m_bnk = (m_bnk + 1) % NB;
        end else if (m_smp < 255) begin
          m_smp = m_smp + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_dsp",   longint'($signed(DSPout)), m_dsp);
    chk("model_idx",   longint'(bunch_idx), longint'(m_idx));
    chk("model_valid", longint'(out_valid), longint'(m_vq[2]));
    chk("model_sat",   longint'(sat_flag),  longint'(m_sat));
  endtask

  task automatic drive(input logic r, input logic st, input logic bs, input logic de,
                       input longint c, input longint s);
    rst        = r;
    store_strb = st;
    bunch_strb = bs;
    delay_en   = de;
    charge_in  = CW'(c);
    signal_in  = SW'(s);
  endtask

  int win_left;
  int exp_idx [4];

  initial begin
    checks = 0; failures = 0;
    model_clear();
    for (int i = 0; i < 3; i++) m_vq[i] = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    // Reset state
    tick(); tick();
    chk("rst_dsp",   longint'($signed(DSPout)), 0);
    chk("rst_idx",   longint'(bunch_idx), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_sat",   longint'(sat_flag), 0);

    // Plain product, three-cycle latency
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1000, 100);
    tick(); tick();
    chk("lat_early_dsp", longint'($signed(DSPout)), 0);
    chk("lat_early_valid", longint'(out_valid), 0);
    tick();
    chk("basic_dsp",   longint'($signed(DSPout)), 24);
    chk("basic_valid", longint'(out_valid), 1);

    // Idle window clears the datapath
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1000, 100);
    tick();
    chk("clear_dsp", longint'($signed(DSPout)), 0);
    tick();

    // Delayed term feeds back: 1 then 2
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4096, 1);
    tick();
    bunch_strb = 1'b0;
    tick(); tick();
    chk("dly_first_dsp", longint'($signed(DSPout)), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("dly_pre_dsp", longint'($signed(DSPout)), 1);
    tick();
    chk("dly_second_dsp", longint'($signed(DSPout)), 2);

    // Four bunches: index wraps and bunch 0's term is reused
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    tick();
    exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 2; exp_idx[3] = 0;
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 2000 + 1500 * p, 3);
      tick();
      bunch_strb = 1'b0;
      tick(); tick(); tick();
      chk("bunch_seq_idx", longint'(bunch_idx), longint'(exp_idx[p]));
      tick(); tick();
    end
    for (int i = 0; i < 6; i++) tick();

    // Reset mid-window discards everything, next window starts from zero terms
    rst = 1'b1;
    tick();
    chk("midrst_dsp",   longint'($signed(DSPout)), 0);
    chk("midrst_idx",   longint'(bunch_idx), 0);
    chk("midrst_valid", longint'(out_valid), 0);
    chk("midrst_sat",   longint'(sat_flag), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4096, 1);
    tick();
    bunch_strb = 1'b0;
    tick();
    chk("postrst_valid", longint'(out_valid), 0);
    tick();
    chk("postrst_dsp", longint'($signed(DSPout)), 1);

    // Extreme operands: clip or wrap depending on build
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1048575, 16383);
    tick(); tick(); tick();
`ifdef FBMULT_SAT_EN
    chk("ext_pos_dsp", longint'($signed(DSPout)), 4095);
    chk("ext_pos_sat", longint'(sat_flag), 1);
`else
    chk("ext_pos_dsp", longint'($signed(DSPout)), -260);
    chk("ext_pos_sat", longint'(sat_flag), 0);
`endif
    charge_in = CW'(-1048576);
    tick(); tick(); tick();
`ifdef FBMULT_SAT_EN
    chk("ext_neg_dsp", longint'($signed(DSPout)), -4096);
    chk("ext_neg_sat", longint'(sat_flag), 1);
`else
    chk("ext_neg_dsp", longint'($signed(DSPout)), 256);
    chk("ext_neg_sat", longint'(sat_flag), 0);
`endif

    // Randomized windows, strobes, operands and occasional resets
    win_left = 0;
    for (int n = 0; n < 1500; n++) begin
      if (win_left == 0) begin
        store_strb = ~store_strb;
        win_left = store_strb ? $urandom_range(6, 60) : $urandom_range(1, 5);
      end else begin
        win_left--;
      end
      rst        = ($urandom_range(0, 199) == 0);
      bunch_strb = ($urandom_range(0, 5) == 0);
      delay_en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        charge_in = CW'($urandom);
        signal_in = SW'($urandom);
      end else begin
        charge_in = CW'($urandom_range(0, 6000));
        signal_in = SW'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) charge_in = -charge_in;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
